// File: rtl/swchrsp_pkt_fifo_ctrl.sv
// Packet-aware store-and-forward FIFO controller for the switch-response packet memory.
// Only whole committed packets are exposed to the registered valid/ready read port.
module swchrsp_pkt_fifo_ctrl #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-2:0] in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic              in_abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-2:0] out_data,
  output logic              out_eop,
  output logic [AWIDTH:0]   pkt_cnt,
  output logic [15:0]       drop_cnt,
  output logic [AWIDTH-1:0] f0_waddr,
  output logic [DWIDTH-1:0] f0_wdata,
  output logic              f0_write,
  output logic [AWIDTH-1:0] f0_raddr,
  input  logic [DWIDTH-1:0] f0_rdata
);

  localparam logic [AWIDTH:0] DEPTH   = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0] PTR_ONE = {{AWIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PKT  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [AWIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [AWIDTH:0]   cm_ptr_q, cm_ptr_d;
  logic [AWIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [DWIDTH-2:0] out_data_q, out_data_d;
  logic              out_eop_q, out_eop_d;
  logic [AWIDTH:0]   pkt_cnt_q, pkt_cnt_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;

  logic full_s;
  logic avail_s;
  logic accept_s;
  logic write_s;
  logic commit_s;
  logic drop_s;
  logic load_s;
  logic pop_s;
  logic pop_eop_s;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

  assign full_s   = (wr_ptr_q - rd_ptr_q) == DEPTH;
  assign avail_s  = (cm_ptr_q != rd_ptr_q);
  assign in_ready = (state_q == ST_DROP) ? 1'b1 : !full_s;
  assign accept_s = in_valid & in_ready;

  assign f0_write = write_s;
  assign f0_waddr = wr_ptr_q[AWIDTH-1:0];
  assign f0_wdata = {in_eop, in_data};
  assign f0_raddr = rd_ptr_q[AWIDTH-1:0];

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_eop   = out_eop_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign drop_cnt  = drop_cnt_q;

  // Write-side framing: decide write, commit, rewind and drop for this cycle.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    cm_ptr_d = cm_ptr_q;
    write_s  = 1'b0;
    commit_s = 1'b0;
    drop_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (in_abort) begin
            wr_ptr_d = cm_ptr_q;
            drop_s   = 1'b1;
            state_d  = in_eop ? ST_IDLE : ST_DROP;
          end else if (in_sop) begin
            write_s  = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (in_eop) begin
              commit_s = 1'b1;
              cm_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
              state_d = ST_PKT;
            end
          end else begin
            drop_s = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PKT: begin
        // An open packet that fills the memory with nothing committed can never drain.
        if (full_s && (cm_ptr_q == rd_ptr_q)) begin
          wr_ptr_d = cm_ptr_q;
          drop_s   = 1'b1;
          state_d  = ST_DROP;
        end else if (accept_s) begin
          if (in_abort) begin
            wr_ptr_d = cm_ptr_q;
            drop_s   = 1'b1;
            state_d  = in_eop ? ST_IDLE : ST_DROP;
          end else begin
            write_s  = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (in_eop) begin
              commit_s = 1'b1;
              cm_ptr_d = wr_ptr_q + PTR_ONE;
              state_d  = ST_IDLE;
            end else begin
              state_d = ST_PKT;
            end
          end
        end else begin
          state_d = ST_PKT;
        end
      end
      ST_DROP: begin
        if (accept_s && in_eop) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        wr_ptr_d = cm_ptr_q;
      end
    endcase
  end

  // Read side: refill the output register whenever it is empty or being consumed.
  always_comb begin
    pop_s       = out_valid_q & out_ready;
    pop_eop_s   = pop_s & out_eop_q;
    load_s      = avail_s & (!out_valid_q | out_ready);
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_eop_d   = out_eop_q;
    if (load_s) begin
      rd_ptr_d    = rd_ptr_q + PTR_ONE;
      out_valid_d = 1'b1;
      out_data_d  = f0_rdata[DWIDTH-2:0];
      out_eop_d   = f0_rdata[DWIDTH-1];
    end else if (pop_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Packet and drop accounting.
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    case ({commit_s, pop_eop_s})
      2'b10:   pkt_cnt_d = pkt_cnt_q + PTR_ONE;
      2'b01:   pkt_cnt_d = pkt_cnt_q - PTR_ONE;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
    if (drop_s) begin
      drop_cnt_d = sat_inc16(drop_cnt_q);
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // State, pointer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= {(AWIDTH+1){1'b0}};
      cm_ptr_q    <= {(AWIDTH+1){1'b0}};
      rd_ptr_q    <= {(AWIDTH+1){1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {(DWIDTH-1){1'b0}};
      out_eop_q   <= 1'b0;
      pkt_cnt_q   <= {(AWIDTH+1){1'b0}};
      drop_cnt_q  <= 16'h0000;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      cm_ptr_q    <= cm_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_eop_q   <= out_eop_d;
      pkt_cnt_q   <= pkt_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_swchrsp_pkt_fifo_ctrl.sv
// Self-checking bench: constant vector table, directed corner sequences and a
// queue-based packet model checked every cycle under random stimulus.
module tb_swchrsp_pkt_fifo_ctrl;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int M_IDLE = 0;
  localparam int M_PKT = 1;
  localparam int M_DROP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid, in_ready, in_sop, in_eop, in_abort;
  logic out_valid, out_ready, out_eop, f0_write;
  logic [DW-2:0] in_data, out_data;
  logic [AW:0] pkt_cnt;
  logic [15:0] drop_cnt;
  logic [AW-1:0] f0_waddr, f0_raddr;
  logic [DW-1:0] f0_wdata, f0_rdata;
  logic [DW-1:0] mem [DEPTH];

  swchrsp_pkt_fifo_ctrl #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop), .in_abort(in_abort),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_eop(out_eop),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt),
    .f0_waddr(f0_waddr), .f0_wdata(f0_wdata), .f0_write(f0_write),
    .f0_raddr(f0_raddr), .f0_rdata(f0_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (f0_write) mem[f0_waddr] <= f0_wdata;
  end
  assign f0_rdata = mem[f0_raddr];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic eop; logic [DW-2:0] d; } beat_t;
  beat_t mq[$];
  beat_t op[$];
  int mode, pkt_m, drop_m;
  bit ov, oe;
  logic [DW-2:0] od;
  bit last_acc, rand_or;

  task automatic model_reset();
    mq.delete(); op.delete();
    mode = M_IDLE; pkt_m = 0; drop_m = 0;
    ov = 1'b0; oe = 1'b0; od = '0;
  endtask

  task automatic step();
    bit full_m, cmp_empty, rdy_m, acc, popped, do_commit, do_drop;
    beat_t b, nb;
    if (rand_or) out_ready = ($urandom_range(0, 3) != 0);
    @(negedge clk);
    full_m = (mq.size() + op.size()) == DEPTH;
    cmp_empty = (mq.size() == 0);
    rdy_m = (mode == M_DROP) ? 1'b1 : !full_m;
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy_m});
    chk("out_valid", {31'd0, out_valid}, {31'd0, ov});
    if (ov) begin
      chk("out_data", {1'b0, out_data}, {1'b0, od});
      chk("out_eop", {31'd0, out_eop}, {31'd0, oe});
    end
    chk("pkt_cnt", {27'd0, pkt_cnt}, pkt_m);
    chk("drop_cnt", {16'd0, drop_cnt}, drop_m);
    acc = in_valid && rdy_m;
    last_acc = acc;
    popped = ov && out_ready;
    if (popped && oe) pkt_m--;
    if (!cmp_empty && (!ov || out_ready)) begin
      b = mq.pop_front();
      ov = 1'b1; od = b.d; oe = b.eop;
    end else if (popped) begin
      ov = 1'b0;
    end
    do_commit = 1'b0;
    do_drop = 1'b0;
    nb.eop = in_eop;
    nb.d = in_data;
    case (mode)
      M_IDLE: if (acc) begin
        if (in_abort) begin
          do_drop = 1'b1; op.delete(); mode = in_eop ? M_IDLE : M_DROP;
        end else if (in_sop) begin
          op.push_back(nb);
          if (in_eop) do_commit = 1'b1; else mode = M_PKT;
        end else begin
          do_drop = 1'b1;
        end
      end
      M_PKT: if (full_m && cmp_empty) begin
        op.delete(); do_drop = 1'b1; mode = M_DROP;
      end else if (acc) begin
        if (in_abort) begin
          do_drop = 1'b1; op.delete(); mode = in_eop ? M_IDLE : M_DROP;
        end else begin
          op.push_back(nb);
          if (in_eop) begin do_commit = 1'b1; mode = M_IDLE; end
        end
      end
      default: if (acc && in_eop) mode = M_IDLE;
    endcase
    if (do_commit) begin
      foreach (op[i]) mq.push_back(op[i]);
      op.delete();
      pkt_m++;
    end
    if (do_drop && drop_m < 65535) drop_m++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc();
    int k;
    k = 0;
    step();
    while (!last_acc && k < 200) begin step(); k++; end
    if (!last_acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_beat(input logic [DW-2:0] d, input bit s, input bit e, input bit a);
    in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e; in_abort = a;
    wait_acc();
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_abort = 1'b0;
  endtask

  task automatic send_pkt(input int len, input logic [DW-2:0] base, input bit abort_last);
    for (int i = 0; i < len; i++)
      send_beat(base + i[DW-2:0], i == 0, i == len - 1, abort_last && (i == len - 1));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic drain();
    int k;
    k = 0;
    in_valid = 1'b0;
    while ((mq.size() > 0 || ov) && k < 600) begin step(); k++; end
    if (k >= 600) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_abort = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit v, s, e, ordy;
    logic [DW-2:0] d;
    bit x_ir, x_ov, x_oe, x_wr;
    logic [DW-2:0] x_od;
    int x_wa, x_pkt, x_drop;
  } vec_t;
  vec_t tbl[10];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_abort = 1'b0;
    in_data = '0; out_ready = 1'b0; rand_or = 1'b0;
    #12;
    do_reset();

    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {1'b0, out_data}, 32'd0);
    chk("rst_out_eop", {31'd0, out_eop}, 32'd0);
    chk("rst_pkt_cnt", {27'd0, pkt_cnt}, 32'd0);
    chk("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_f0_write", {31'd0, f0_write}, 32'd0);
    chk("rst_f0_raddr", {28'd0, f0_raddr}, 32'd0);

    // Test 1: 4-beat packet, out_ready=1, first beat one cycle after EOP edge.
    //            v  s  e  or d        ir ov oe wr od       wa pkt drop
    tbl[0] = '{1, 1, 0, 1, 31'h0A0, 1, 0, 0, 1, 31'h000, 0, 0, 0};
    tbl[1] = '{1, 0, 0, 1, 31'h0A1, 1, 0, 0, 1, 31'h000, 1, 0, 0};
    tbl[2] = '{1, 0, 0, 1, 31'h0A2, 1, 0, 0, 1, 31'h000, 2, 0, 0};
    tbl[3] = '{1, 0, 1, 1, 31'h0A3, 1, 0, 0, 1, 31'h000, 3, 0, 0};
    tbl[4] = '{0, 0, 0, 1, 31'h000, 1, 0, 0, 0, 31'h000, 0, 1, 0};
    tbl[5] = '{0, 0, 0, 1, 31'h000, 1, 1, 0, 0, 31'h0A0, 0, 1, 0};
    tbl[6] = '{0, 0, 0, 1, 31'h000, 1, 1, 0, 0, 31'h0A1, 0, 1, 0};
    tbl[7] = '{0, 0, 0, 1, 31'h000, 1, 1, 0, 0, 31'h0A2, 0, 1, 0};
    tbl[8] = '{0, 0, 0, 1, 31'h000, 1, 1, 1, 0, 31'h0A3, 0, 1, 0};
    tbl[9] = '{0, 0, 0, 1, 31'h000, 1, 0, 0, 0, 31'h000, 0, 0, 0};
    foreach (tbl[i]) begin
      in_valid = tbl[i].v; in_sop = tbl[i].s; in_eop = tbl[i].e;
      in_abort = 1'b0; in_data = tbl[i].d; out_ready = tbl[i].ordy;
      #1;
      chk("t1_in_ready", {31'd0, in_ready}, {31'd0, tbl[i].x_ir});
      chk("t1_out_valid", {31'd0, out_valid}, {31'd0, tbl[i].x_ov});
      chk("t1_f0_write", {31'd0, f0_write}, {31'd0, tbl[i].x_wr});
      if (tbl[i].x_ov) begin
        chk("t1_out_data", {1'b0, out_data}, {1'b0, tbl[i].x_od});
        chk("t1_out_eop", {31'd0, out_eop}, {31'd0, tbl[i].x_oe});
      end
      if (tbl[i].x_wr) begin
        chk("t1_f0_waddr", {28'd0, f0_waddr}, tbl[i].x_wa);
        chk("t1_f0_wdata", f0_wdata, {tbl[i].e, tbl[i].d});
      end
      chk("t1_pkt_cnt", {27'd0, pkt_cnt}, tbl[i].x_pkt);
      chk("t1_drop_cnt", {16'd0, drop_cnt}, tbl[i].x_drop);
      step();
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;

    // Test 2: abort on the third beat rewinds; next packet starts at address 0.
    do_reset();
    out_ready = 1'b1;
    send_pkt(3, 31'h100, 1'b1);
    idle(3);
    chk("t2_drop_cnt", {16'd0, drop_cnt}, 32'd1);
    chk("t2_out_valid", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b0; in_abort = 1'b0; in_data = 31'h200;
    #1;
    chk("t2_f0_waddr", {28'd0, f0_waddr}, 32'd0);
    chk("t2_f0_write", {31'd0, f0_write}, 32'd1);
    wait_acc();
    send_beat(31'h201, 1'b0, 1'b1, 1'b0);
    drain();
    chk("t2_pkt_cnt", {27'd0, pkt_cnt}, 32'd0);

    // Test 3: 20-beat packet with reader stalled overflows the memory.
    do_reset();
    out_ready = 1'b0;
    send_pkt(20, 31'h300, 1'b0);
    idle(3);
    chk("t3_drop_cnt", {16'd0, drop_cnt}, 32'd1);
    chk("t3_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t3_in_ready", {31'd0, in_ready}, 32'd1);

    // Test 4: fill memory with committed data, backpressure, then drain in order.
    do_reset();
    out_ready = 1'b0;
    send_pkt(8, 31'h400, 1'b0);
    send_pkt(8, 31'h500, 1'b0);
    send_beat(31'h600, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 31'h601;
    #1;
    chk("t4_in_ready_full", {31'd0, in_ready}, 32'd0);
    step();
    chk("t4_out_valid_held", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    wait_acc();
    send_beat(31'h602, 1'b0, 1'b1, 1'b0);
    drain();
    chk("t4_in_ready_back", {31'd0, in_ready}, 32'd1);
    chk("t4_pkt_cnt", {27'd0, pkt_cnt}, 32'd0);

    // Test 5: stray body beat in IDLE, then random reader stalls.
    do_reset();
    out_ready = 1'b1;
    send_beat(31'h700, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("t5_drop_cnt", {16'd0, drop_cnt}, 32'd1);
    rand_or = 1'b1;
    for (int p = 0; p < 6; p++) send_pkt(1 + p, 31'h710 + 31'(p * 16), 1'b0);
    drain();
    rand_or = 1'b0;

    // Test 6: reset while a packet is held on the output and another is open.
    out_ready = 1'b0;
    send_pkt(5, 31'h800, 1'b0);
    send_beat(31'h810, 1'b1, 1'b0, 1'b0);
    send_beat(31'h811, 1'b0, 1'b0, 1'b0);
    idle(1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_async_pkt_cnt", {27'd0, pkt_cnt}, 32'd0);
    chk("t6_async_in_ready", {31'd0, in_ready}, 32'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rand_or = 1'b1;
    for (int p = 0; p < 40; p++) begin
      if ($urandom_range(0, 7) == 0) send_beat(31'($urandom), 1'b0, 1'b0, 1'b0);
      send_pkt($urandom_range(1, 12), 31'($urandom) & 31'h7FFF0000,
               $urandom_range(0, 9) == 0);
      idle($urandom_range(0, 2));
    end
    drain();
    rand_or = 1'b0;
    chk("t6_final_pkt_cnt", {27'd0, pkt_cnt}, 32'd0);
    chk("t6_final_drop_cnt", {16'd0, drop_cnt}, drop_m);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule
